// File: rtl/pipe_stage_pkg.sv
// Shared types for the generic pipeline-stage register: state encoding,
// counter width default and the per-stage payload structs sized with $bits().
package pipe_stage_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } pipe_state_t;

   localparam int PIPE_CNT_W = 32;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ifid_payload_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [3:0]  alu_op;
      logic        alu_src;
      logic        mem_rd;
      logic        mem_wr;
      logic        reg_wr;
      logic        mem_to_reg;
   } idex_payload_t;

   typedef struct packed {
      logic [31:0] alu_res;
      logic [31:0] st_data;
      logic [4:0]  rd;
      logic        mem_rd;
      logic        mem_wr;
      logic        reg_wr;
      logic        mem_to_reg;
   } exmem_payload_t;

   typedef struct packed {
      logic [31:0] alu_res;
      logic [31:0] ld_data;
      logic [4:0]  rd;
      logic        reg_wr;
      logic        mem_to_reg;
   } memwb_payload_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter: counts up on inc, then sticks at all-ones.
module pipe_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         cnt <= '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic two-entry (main + skid) pipeline-stage register with valid/ready,
// global advance enable and flush. Counters compiled in with PIPE_STAGE_PERF_EN.
module pipe_stage_reg
   import pipe_stage_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int CNT_W  = PIPE_CNT_W
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              en,
   input  logic              flush,
   input  logic              up_valid,
   input  logic [DATA_W-1:0] up_data,
   output logic              up_ready,
   output logic              dn_valid,
   output logic [DATA_W-1:0] dn_data,
   input  logic              dn_ready
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output logic [CNT_W-1:0]  xfer_cnt
`endif
);

   if (DATA_W < 1 || CNT_W < 1) begin : g_param_chk
      $error("pipe_stage_reg: DATA_W and CNT_W must be positive");
   end

   pipe_state_t       state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              up_x, dn_x;

   // Outputs depend only on registered state, so dn_ready never reaches up_ready.
   assign up_ready = (state_q != SKID);
   assign dn_valid = (state_q != EMPTY);
   assign dn_data  = main_q;

   assign up_x = en & up_valid & up_ready & ~flush;
   assign dn_x = en & dn_valid & dn_ready & ~flush;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (up_x) begin
               state_d = FULL;
               main_d  = up_data;
            end
         end
         FULL: begin
            if (up_x && dn_x) begin
               main_d = up_data;
            end else if (up_x) begin
               state_d = SKID;
               skid_d  = up_data;
            end else if (dn_x) begin
               state_d = EMPTY;
            end
         end
         SKID: begin
            if (dn_x) begin
               state_d = FULL;
               main_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush overrides any transfer decided above.
      if (en && flush) begin
         state_d = EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .CLK  (CLK),
      .nRST (nRST),
      .inc  (en & dn_valid & ~dn_ready & ~flush),
      .cnt  (stall_cnt)
   );

   pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
      .CLK  (CLK),
      .nRST (nRST),
      .inc  (en & flush),
      .cnt  (flush_cnt)
   );

   pipe_perf_cnt #(.CNT_W(CNT_W)) u_xfer_cnt (
      .CLK  (CLK),
      .nRST (nRST),
      .inc  (dn_x),
      .cnt  (xfer_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, async reset check, and a
// randomized run against a queue-based reference model.
module tb_pipe_stage_reg;

   localparam int DW = 128;

   logic          CLK = 1'b0;
   logic          nRST;
   logic          en, flush, up_valid, dn_ready;
   logic [DW-1:0] up_data;
   logic          up_ready, dn_valid;
   logic [DW-1:0] dn_data;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

`ifdef PIPE_STAGE_PERF_EN
   logic [31:0]   stall_cnt, flush_cnt, xfer_cnt;
   logic          up_ready4, dn_valid4;
   logic [DW-1:0] dn_data4;
   logic [3:0]    stall_cnt4, flush_cnt4, xfer_cnt4;

   pipe_stage_reg #(.DATA_W(DW), .CNT_W(4)) dut4 (
      .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
      .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready4),
      .dn_valid(dn_valid4), .dn_data(dn_data4), .dn_ready(dn_ready),
      .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4), .xfer_cnt(xfer_cnt4)
   );
`endif

   pipe_stage_reg #(.DATA_W(DW), .CNT_W(32)) dut (
      .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
      .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready),
      .dn_valid(dn_valid), .dn_data(dn_data), .dn_ready(dn_ready)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .xfer_cnt(xfer_cnt)
`endif
   );

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference model: the stage is a FIFO of depth two; when empty, dn_data
   // shows the last payload that left (or zero after reset/flush).
   logic [DW-1:0] mq[$];
   logic [DW-1:0] hold;
   longint        m_stall, m_flush, m_xfer;

   task automatic model_reset();
      mq.delete();
      hold    = '0;
      m_stall = 0;
      m_flush = 0;
      m_xfer  = 0;
   endtask

   task automatic model_edge();
      bit can_push, has_out;
      can_push = (mq.size() < 2);
      has_out  = (mq.size() > 0);
      if (en) begin
         if (flush) begin
            mq.delete();
            hold = '0;
            m_flush++;
         end else begin
            if (has_out && !dn_ready) m_stall++;
            if (has_out && dn_ready) begin
               hold = mq.pop_front();
               m_xfer++;
            end
            if (up_valid && can_push) mq.push_back(up_data);
         end
      end
   endtask

   task automatic chk_model(input string tag);
      logic [DW-1:0] exp_dd;
      exp_dd = (mq.size() > 0) ? mq[0] : hold;
      chk({tag, "_ur"}, DW'(up_ready), DW'(mq.size() < 2));
      chk({tag, "_dv"}, DW'(dn_valid), DW'(mq.size() > 0));
      chk({tag, "_dd"}, dn_data, exp_dd);
`ifdef PIPE_STAGE_PERF_EN
      chk({tag, "_stall"}, DW'(stall_cnt), DW'(m_stall));
      chk({tag, "_flush"}, DW'(flush_cnt), DW'(m_flush));
      chk({tag, "_xfer"},  DW'(xfer_cnt),  DW'(m_xfer));
      chk({tag, "_stall4"}, DW'(stall_cnt4), DW'((m_stall > 15) ? 15 : m_stall));
      chk({tag, "_flush4"}, DW'(flush_cnt4), DW'((m_flush > 15) ? 15 : m_flush));
      chk({tag, "_xfer4"},  DW'(xfer_cnt4),  DW'((m_xfer > 15) ? 15 : m_xfer));
`endif
   endtask

   task automatic drive(input logic e, input logic f, input logic uv, input int d, input logic dr);
      en       = e;
      flush    = f;
      up_valid = uv;
      up_data  = DW'(d);
      dn_ready = dr;
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
      nRST = 1'b0;
      #12;
      @(negedge CLK);
      nRST = 1'b1;
      model_reset();
   endtask

   typedef struct {
      logic          en, fl, uv, dr;
      int            ud;
      logic          e_ur, e_dv;
      int            e_dd;
   } vec_t;

   vec_t tbl[$];

   task automatic addv(input logic e, input logic f, input logic uv, input int d,
                       input logic dr, input logic ur, input logic dv, input int dd);
      vec_t v;
      v.en = e; v.fl = f; v.uv = uv; v.ud = d; v.dr = dr;
      v.e_ur = ur; v.e_dv = dv; v.e_dd = dd;
      tbl.push_back(v);
   endtask

   initial begin
      //    en fl uv data  dr   ur dv dd   (outputs after the edge)
      // streaming 1,2,3 then drain
      addv(1, 0, 1, 'h01, 1,   1, 1, 'h01);
      addv(1, 0, 1, 'h02, 1,   1, 1, 'h02);
      addv(1, 0, 1, 'h03, 1,   1, 1, 'h03);
      addv(1, 0, 0, 'h00, 1,   1, 0, 'h03);
      // skid fill, upstream held, then release in order
      addv(1, 0, 1, 'h10, 0,   1, 1, 'h10);
      addv(1, 0, 1, 'h11, 0,   0, 1, 'h10);
      addv(1, 0, 1, 'h12, 0,   0, 1, 'h10);
      addv(1, 0, 1, 'h12, 1,   1, 1, 'h11);
      addv(1, 0, 1, 'h12, 1,   1, 1, 'h12);
      addv(1, 0, 0, 'h00, 1,   1, 0, 'h12);
      // flush while in SKID with a concurrent offer of 0x33
      addv(1, 0, 1, 'h20, 0,   1, 1, 'h20);
      addv(1, 0, 1, 'h21, 0,   0, 1, 'h20);
      addv(1, 1, 1, 'h33, 1,   1, 0, 'h00);
      addv(1, 0, 0, 'h00, 1,   1, 0, 'h00);
      // freeze in FULL for four cycles
      addv(1, 0, 1, 'h7E, 0,   1, 1, 'h7E);
      addv(0, 1, 1, 'h55, 1,   1, 1, 'h7E);
      addv(0, 1, 1, 'h55, 1,   1, 1, 'h7E);
      addv(0, 1, 1, 'h55, 1,   1, 1, 'h7E);
      addv(0, 1, 1, 'h55, 1,   1, 1, 'h7E);
      addv(1, 0, 0, 'h00, 1,   1, 0, 'h7E);
      // flush in FULL with dn_ready high
      addv(1, 0, 1, 'h40, 0,   1, 1, 'h40);
      addv(1, 1, 0, 'h00, 1,   1, 0, 'h00);

      do_reset();
      chk("rst_ur", DW'(up_ready), DW'(1));
      chk("rst_dv", DW'(dn_valid), DW'(0));
      chk("rst_dd", dn_data, '0);

      foreach (tbl[i]) begin
         drive(tbl[i].en, tbl[i].fl, tbl[i].uv, tbl[i].ud, tbl[i].dr);
         @(posedge CLK);
         #1;
         chk($sformatf("vec%0d_ur", i), DW'(up_ready), DW'(tbl[i].e_ur));
         chk($sformatf("vec%0d_dv", i), DW'(dn_valid), DW'(tbl[i].e_dv));
         chk($sformatf("vec%0d_dd", i), dn_data, DW'(tbl[i].e_dd));
      end

      // asynchronous reset while FULL with 0xA5
      do_reset();
      drive(1, 0, 1, 'hA5, 0);
      step();
      chk("pre_rst_dd", dn_data, DW'('hA5));
      drive(1, 0, 1, 'h5A, 1);
      #2;
      nRST = 1'b0;
      #1;
      chk("async_rst_dv", DW'(dn_valid), DW'(0));
      chk("async_rst_dd", dn_data, '0);
      chk("async_rst_ur", DW'(up_ready), DW'(1));
      @(negedge CLK);
      nRST = 1'b1;
      model_reset();

`ifdef PIPE_STAGE_PERF_EN
      // 5 stalls, 2 flushes, 3 transfers
      drive(1, 0, 1, 'h01, 0);
      step();
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 0, 0, 0);
         step();
      end
      for (int i = 0; i < 2; i++) begin
         drive(1, 1, 0, 0, 0);
         step();
      end
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, (i < 3), 'hC0 + i, 1);
         step();
      end
      chk("perf_stall", DW'(stall_cnt), DW'(5));
      chk("perf_flush", DW'(flush_cnt), DW'(2));
      chk("perf_xfer",  DW'(xfer_cnt),  DW'(3));
      // 20 back-to-back transfers saturate the 4-bit counter
      for (int i = 0; i < 21; i++) begin
         drive(1, 0, 1, i, 1);
         step();
      end
      chk("perf_xfer4_sat", DW'(xfer_cnt4), DW'(15));
      chk("perf_xfer32",    DW'(xfer_cnt),  DW'(23));
      do_reset();
`endif

      // randomized run against the reference model
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 9) < 7, int'($urandom()), $urandom_range(0, 9) < 6);
         step();
         chk_model($sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, generic pipeline-stage register. It replaces the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. The block carries an opaque payload of DATA_W bits through a two-entry (main + skid) buffer with a valid/ready handshake, a global advance enable (driven by ihit), and a synchronous flush. The payload is a packed struct of stage control and data fields assembled by the instantiating datapath.

## Interface
- DATA_W, 128: payload width in bits.
- CNT_W, 32: width of each performance counter. Used only under PIPE_STAGE_PERF_EN.
- CLK  input  1  clock; all state updates on the rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- en  input  1  global advance enable (ihit). When 0, no state change of any kind.
- flush  input  1  squash stage contents. Takes effect only when en=1.
- up_valid  input  1  upstream offers payload.
- up_data  input  DATA_W  upstream payload.
- up_ready  output  1  stage can accept a payload.
- dn_valid  output  1  stage holds a valid payload.
- dn_data  output  DATA_W  payload presented downstream.
- dn_ready  input  1  downstream accepts payload.
- stall_cnt, flush_cnt, xfer_cnt  output  CNT_W each  performance counters. These ports exist only under PIPE_STAGE_PERF_EN.

## Operation
- **State register**, values EMPTY, FULL, SKID. Data registers main_q and skid_q, each DATA_W bits.
- **Outputs:**
  - up_ready = (state != SKID).
  - dn_valid = (state != EMPTY).
  - dn_data = main_q.
  - All three are purely registered; there is no combinational path from dn_ready to up_ready.
- **Transfer qualifiers:**
  - up_x = en & up_valid & up_ready & !flush.
  - dn_x = en & dn_valid & dn_ready & !flush.
- **Priority:** reset > (en & flush) > transfers > hold.
- **Flush (en=1):**
  - state <= EMPTY; main_q and skid_q <= 0.
  - Any concurrent up_valid is dropped, not latched.
  - Any concurrent dn_ready does not count as a transfer.
- **Transitions:**
  - EMPTY: up_x → FULL, main_q <= up_data.
  - FULL: up_x & dn_x → FULL, main_q <= up_data.
  - FULL: up_x only → SKID, skid_q <= up_data.
  - FULL: dn_x only → EMPTY. main_q is retained, but dn_valid=0 so its value is don't-care.
  - SKID: dn_x → FULL, main_q <= skid_q. up_data is ignored because up_ready=0.
- **en=0:** state and data hold, irrespective of flush, up_valid or dn_ready. Outputs stay stable.
- **Illegal state encoding:** recover to EMPTY on the next edge.

## Timing
- **Reset values:** state=EMPTY; main_q, skid_q = 0; dn_valid=0; dn_data=0; up_ready=1; counters = 0.
- **Latency:** one cycle. A payload accepted at edge N appears on dn_data after edge N when the stage was EMPTY or draining.
- **Throughput:** one payload per cycle while dn_ready=1 and en=1.
- **Skid:** one cycle of downstream stall absorbs one extra payload. up_ready falls only in the cycle after the skid entry fills.
- **Ordering:** FIFO; payload order is always preserved.
- **Reset mid-operation:** any held payload is discarded immediately, asynchronously.
- **Simultaneous flush and reset:** reset wins.

## Configuration
- **Macro:** PIPE_STAGE_PERF_EN.
- **When defined:** three saturating CNT_W-bit counters are compiled in, each holding at all-ones:
  - stall_cnt increments when en & dn_valid & !dn_ready & !flush.
  - flush_cnt increments when en & flush.
  - xfer_cnt increments on dn_x.
- **When undefined:** the counter ports and logic are absent, and behaviour is otherwise identical.

## Structure
- **Shared package** pipe_stage_pkg holds:
  - typedef enum logic [1:0] pipe_state_t {EMPTY, FULL, SKID};
  - localparam PIPE_CNT_W = 32;
  - the per-stage payload struct typedefs (idex_payload_t and others), so that instantiations use $bits() for DATA_W.
- **Sub-module:** one, pipe_perf_cnt, a saturating counter with parameter CNT_W, instantiated three times under the macro.

## Test plan
- **Reset:** assert nRST=0 mid-stream while FULL with main_q=0xA5 → dn_valid=0, dn_data=0, up_ready=1 immediately, with no clock edge required.
- **Streaming:** en=1, dn_ready=1, payloads 1,2,3 on consecutive cycles → dn_data shows 1,2,3 one cycle later each; up_ready stays 1.
- **Skid:** stream 0x10, 0x11, 0x12 with dn_ready=0 from the cycle 0x10 appears → state reaches SKID holding 0x10/0x11, up_ready=0, 0x12 held upstream. Raise dn_ready → out 0x10, 0x11, 0x12 in order with nothing lost.
- **Flush:** en=1, flush=1 in SKID with up_valid=1 carrying 0x33 → next cycle EMPTY, dn_valid=0, dn_data=0, and 0x33 is never output.
- **Freeze:** en=0 with flush=1, up_valid=1, dn_ready=1 for 4 cycles in FULL (0x7E) → state, dn_data=0x7E and up_ready are unchanged.
- **Performance counters (PIPE_STAGE_PERF_EN):** 5 stall cycles, 2 flushes, 3 transfers → stall_cnt=5, flush_cnt=2, xfer_cnt=3. With CNT_W=4 and 20 transfers → xfer_cnt=15 (saturated).
